m_seq_chk: RTL and testbench
============================

Name: m_seq_chk

Overview:
Receive-side M-sequence checker, the far end of the m_seq_gen pattern source on the QAM test link. It takes the demodulated bit stream with a per-bit valid strobe and self-synchronises a local LFSR to the incoming pattern. Once locked, it free-runs that LFSR, flags every mismatching bit, and accumulates bit and error counts for BER measurement.

Parameters:
- REG_LEN, 4, LFSR length. Supported range is 2..13 with the same tap set as m_seq_gen. Any other value is an elaboration error.
- LOCK_CNT, 8, consecutive matching bits in SEARCH required to declare lock.
- WINDOW_LEN, 64, length in valid bits of the loss-of-lock observation window.
- LOSS_THRESH, 4, errors tolerated per window. Error number LOSS_THRESH+1 within one window drops lock.
- CNT_W, 32, width of bit_cnt and err_cnt.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous, active-high reset.
- bit_in, in, 1, received bit. Sampled only when bit_valid=1.
- bit_valid, in, 1, level-qualified strobe. One bit is consumed per cycle in which it is high.
- clr_cnt, in, 1, synchronous clear of bit_cnt and err_cnt.
- locked, out, 1, high while in the LOCKED state.
- bit_err, out, 1, one-cycle pulse for a mismatching bit while locked.
- lock_lost, out, 1, one-cycle pulse on the LOCKED->SEARCH transition.
- bit_cnt, out, CNT_W, bits checked while locked. Saturates at all-ones.
- err_cnt, out, CNT_W, errors counted while locked. Saturates at all-ones.

Behaviour:
- Generator model:
  - Transmitted bit = state[REG_LEN-1].
  - On each step the state shifts toward the MSB and the LSB is filled with fb(state) = XOR of the tap bits.
  - For REG_LEN=4 the taps are bits 0 and 3.
  - Consequence: if register r holds the last REG_LEN received bits (newest in LSB), the next expected bit is fb(r).
- Reset (rst=1 at a clock edge):
  - r=0, fill_cnt=0, match_cnt=0, win_cnt=0, win_err=0, state=SEARCH.
  - All outputs 0. Reset takes effect in any state.
- Cycles with bit_valid=0: all state holds and bit_err/lock_lost are 0.
- SEARCH, on each valid bit:
  - r <= {r[REG_LEN-2:0], bit_in}.
  - While fill_cnt<REG_LEN: fill_cnt++, no comparison.
  - Otherwise: if bit_in==fb(r) and r!=0, then match_cnt++; else match_cnt=0.
  - The r!=0 qualifier stops an all-zero stream from ever locking.
  - When match_cnt reaches LOCK_CNT: next state LOCKED, win_cnt=0, win_err=0.
- LOCKED, on each valid bit:
  - Flywheel: r <= {r[REG_LEN-2:0], fb(r)}. Received bits are never loaded, so one channel error gives exactly one bit_err.
  - mismatch = bit_in ^ fb(r).
  - bit_cnt++; if mismatch, err_cnt++ and win_err++.
  - win_cnt++. When win_cnt wraps at WINDOW_LEN, both win_cnt and win_err restart at 0. The current bit's error goes into the new window.
  - If mismatch and win_err==LOSS_THRESH before the increment: next state SEARCH, lock_lost=1, fill_cnt=0, match_cnt=0.
  - Counters and bit_err still record that final error.
- Latency: bit_err, lock_lost, locked and the counters are registered and change 1 cycle after the clock edge that samples the valid bit.
- Counting starts with the first valid bit after locked goes high.
- Saturation: each counter holds at 2^CNT_W-1 and the other counter keeps running.
- clr_cnt has priority over a simultaneous increment: both counters read 0 on the next cycle and the coincident bit is not counted. bit_err still pulses.

Decomposition:
- Shared package m_seq_pkg, also used by m_seq_gen:
  - Tap-mask constant table indexed by REG_LEN (2..13).
  - Function m_seq_fb(state, REG_LEN) returning the XOR of the masked bits.
  - State enum {SEARCH, LOCKED}.
- The LFSR and lock FSM live inline.
- Optional sub-module m_seq_sat_cnt: saturating counter with clear and increment, instantiated twice.

Test Plan:
All scenarios use REG_LEN=4, LOCK_CNT=8, WINDOW_LEN=64, LOSS_THRESH=4. Reference sequence from all-ones (period 15): 111101011001000.
1. Sequence repeated from reset, bit_valid=1 every cycle -> locked rises 1 cycle after the 12th valid bit; then bit_cnt +1 per bit, err_cnt=0, bit_err never high.
2. After lock, invert one bit -> exactly one bit_err pulse, err_cnt=1, locked stays 1, following bits error-free.
3. After lock, invert 5 bits within 20 bits -> lock_lost pulses on the 5th error and locked=0 next cycle, err_cnt=5; clean stream re-locks after 12 more valid bits.
4. Constant 0 input for 100 bits -> locked stays 0. Constant 1 input -> also never locks (fb(1111)=0 mismatches).
5. bit_valid high one cycle in three, sequence as in 1 -> same lock point counted in valid bits; outputs unchanged during invalid cycles.
6. clr_cnt asserted in the same cycle as an erroneous valid bit -> bit_err pulses, bit_cnt=err_cnt=0 next cycle. Then rst while locked -> locked=0 and counters 0 the following cycle.

Source files
------------

// File: rtl/m_seq_pkg.sv
// Shared M-sequence definitions for the pattern generator and checker:
// maximal-length tap masks for lengths 2..13, feedback function, lock FSM states.
package m_seq_pkg;

   localparam int MSEQ_MAX_LEN = 13;

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } m_seq_state_e;

   // Bit i set means state[i] feeds the XOR; state[len-1] is always a tap.
   function automatic logic [MSEQ_MAX_LEN-1:0] m_seq_taps(input int len);
      case (len)
         2:       return 13'h0003;
         3:       return 13'h0005;
         4:       return 13'h0009;
         5:       return 13'h0012;
         6:       return 13'h0021;
         7:       return 13'h0041;
         8:       return 13'h008E;
         9:       return 13'h0108;
         10:      return 13'h0204;
         11:      return 13'h0402;
         12:      return 13'h0CA0;
         13:      return 13'h1B00;
         default: return 13'h0000;
      endcase
   endfunction

   function automatic logic m_seq_fb(input logic [MSEQ_MAX_LEN-1:0] state, input int len);
      return ^(state & m_seq_taps(len));
   endfunction

endpackage

// File: rtl/m_seq_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// One-cycle update latency, holds at all-ones.
module m_seq_sat_cnt #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= '0;
      end else if (inc && (q != '1)) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/m_seq_chk.sv
// Self-synchronising M-sequence checker with flywheel LFSR, windowed loss-of-lock and BER counters.
// All outputs registered, 1 cycle after the sampling edge; no backpressure, one bit per valid cycle.
module m_seq_chk
   import m_seq_pkg::*;
#(
   parameter int REG_LEN     = 4,
   parameter int LOCK_CNT    = 8,
   parameter int WINDOW_LEN  = 64,
   parameter int LOSS_THRESH = 4,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_in,
   input  logic             bit_valid,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             bit_err,
   output logic             lock_lost,
   output logic [CNT_W-1:0] bit_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   generate
      if (REG_LEN < 2 || REG_LEN > MSEQ_MAX_LEN) begin : g_bad_len
         $error("m_seq_chk: REG_LEN must be in 2..13");
      end
      if (LOCK_CNT < 1 || WINDOW_LEN < 2 || LOSS_THRESH < 0) begin : g_bad_cfg
         $error("m_seq_chk: LOCK_CNT>=1, WINDOW_LEN>=2, LOSS_THRESH>=0 required");
      end
   endgenerate

   localparam int FW = $clog2(REG_LEN + 1);
   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int WW = $clog2(WINDOW_LEN);
   localparam int EW = $clog2(LOSS_THRESH + 2);

   localparam logic [FW-1:0] FILL_FULL = FW'(REG_LEN);
   localparam logic [MW-1:0] LOCK_VAL  = MW'(LOCK_CNT);
   localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW_LEN - 1);
   localparam logic [EW-1:0] THRESH    = EW'(LOSS_THRESH);

   m_seq_state_e        state;
   m_seq_state_e        state_nxt;
   logic [REG_LEN-1:0]  r;
   logic [FW-1:0]       fill_cnt;
   logic [MW-1:0]       match_cnt;
   logic [MW-1:0]       match_inc;
   logic [WW-1:0]       win_cnt;
   logic [EW-1:0]       win_err;
   logic [EW-1:0]       win_base;
   logic                fb;
   logic                mismatch;
   logic                seq_match;
   logic                fill_done;
   logic                win_wrap;
   logic                drop;
   logic                cnt_inc;

   always_comb begin
      fb        = m_seq_fb(MSEQ_MAX_LEN'(r), REG_LEN);
      mismatch  = bit_in ^ fb;
      seq_match = (bit_in == fb) && (r != '0);
      fill_done = (fill_cnt == FILL_FULL);
      match_inc = match_cnt + MW'(1);
      win_wrap  = (win_cnt == WIN_LAST);
      // The bit that wraps the window is charged to the new window.
      win_base  = win_wrap ? '0 : win_err;
      drop      = mismatch && (win_base == THRESH);
      cnt_inc   = bit_valid && (state == LOCKED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SEARCH;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (bit_valid) begin
         case (state)
            SEARCH: begin
               if (fill_done && seq_match && (match_inc == LOCK_VAL)) begin
                  state_nxt = LOCKED;
               end
            end
            LOCKED: begin
               if (drop) begin
                  state_nxt = SEARCH;
               end
            end
            default: state_nxt = SEARCH;
         endcase
      end
   end

   always_comb begin
      locked = (state == LOCKED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r         <= '0;
         fill_cnt  <= '0;
         match_cnt <= '0;
         win_cnt   <= '0;
         win_err   <= '0;
         bit_err   <= 1'b0;
         lock_lost <= 1'b0;
      end else begin
         bit_err   <= 1'b0;
         lock_lost <= 1'b0;
         if (bit_valid) begin
            case (state)
               SEARCH: begin
                  r <= {r[REG_LEN-2:0], bit_in};
                  if (!fill_done) begin
                     fill_cnt <= fill_cnt + FW'(1);
                  end else if (seq_match) begin
                     match_cnt <= match_inc;
                  end else begin
                     match_cnt <= '0;
                  end
                  if (state_nxt == LOCKED) begin
                     win_cnt <= '0;
                     win_err <= '0;
                  end
               end
               LOCKED: begin
                  // Flywheel: received bits never enter r once locked.
                  r       <= {r[REG_LEN-2:0], fb};
                  bit_err <= mismatch;
                  win_cnt <= win_wrap ? '0 : win_cnt + WW'(1);
                  win_err <= win_base + EW'(mismatch);
                  if (drop) begin
                     lock_lost <= 1'b1;
                     fill_cnt  <= '0;
                     match_cnt <= '0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   m_seq_sat_cnt #(.W(CNT_W)) u_bit_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr_cnt),
      .inc (cnt_inc),
      .q   (bit_cnt)
   );

   m_seq_sat_cnt #(.W(CNT_W)) u_err_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr_cnt),
      .inc (cnt_inc && mismatch),
      .q   (err_cnt)
   );

endmodule

// File: tb/tb_m_seq_chk.sv
// Directed-plus-random bench for m_seq_chk against a recurrence-based reference model.
module tb_m_seq_chk;

   localparam int  REG_LEN     = 4;
   localparam int  LOCK_CNT    = 8;
   localparam int  WINDOW_LEN  = 64;
   localparam int  LOSS_THRESH = 4;
   localparam int  CNT_W       = 32;
   localparam longint MAXC     = 64'h0000_0000_FFFF_FFFF;

   logic             clk = 1'b0;
   logic             rst;
   logic             bit_in;
   logic             bit_valid;
   logic             clr_cnt;
   logic             locked;
   logic             bit_err;
   logic             lock_lost;
   logic [CNT_W-1:0] bit_cnt;
   logic [CNT_W-1:0] err_cnt;

   always #5 clk = ~clk;

   m_seq_chk #(
      .REG_LEN     (REG_LEN),
      .LOCK_CNT    (LOCK_CNT),
      .WINDOW_LEN  (WINDOW_LEN),
      .LOSS_THRESH (LOSS_THRESH),
      .CNT_W       (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bit_in    (bit_in),
      .bit_valid (bit_valid),
      .clr_cnt   (clr_cnt),
      .locked    (locked),
      .bit_err   (bit_err),
      .lock_lost (lock_lost),
      .bit_cnt   (bit_cnt),
      .err_cnt   (err_cnt)
   );

   int     checks = 0;
   int     errors = 0;
   string  seq_str;
   int     pos;

   // Reference model: history of the pattern as the checker should believe it.
   logic   ref_q[$];
   int     m_locked, m_n, m_run, m_k, m_wid, m_werr;
   longint m_bits, m_errs;
   logic   m_err, m_lost;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, want);
      end
   endtask

   task automatic get_bit(output logic b);
      b = (seq_str.getc(pos % 15) == "1");
      pos++;
   endtask

   task automatic model_reset();
      ref_q.delete();
      m_locked = 0; m_n = 0; m_run = 0; m_k = 0; m_wid = 0; m_werr = 0;
      m_bits = 0; m_errs = 0; m_err = 1'b0; m_lost = 1'b0;
   endtask

   task automatic model_update(input logic b, input logic v, input logic c);
      logic nb, nz, p, mis;
      int   sz, wid;
      m_err  = 1'b0;
      m_lost = 1'b0;
      if (v) begin
         sz = ref_q.size();
         if (m_locked == 0) begin
            if (m_n < REG_LEN) begin
               m_n++;
            end else begin
               // Pattern recurrence b[t] = b[t-1] ^ b[t-4]
               nb = ref_q[sz-1] ^ ref_q[sz-4];
               nz = ref_q[sz-1] | ref_q[sz-2] | ref_q[sz-3] | ref_q[sz-4];
               if (b == nb && nz) m_run++;
               else               m_run = 0;
            end
            ref_q.push_back(b);
            if (m_run == LOCK_CNT) begin
               m_locked = 1; m_k = 0; m_wid = 0; m_werr = 0;
            end
         end else begin
            p = ref_q[sz-1] ^ ref_q[sz-4];
            ref_q.push_back(p);
            mis = b ^ p;
            m_k++;
            wid = m_k / WINDOW_LEN;
            if (wid != m_wid) begin
               m_wid  = wid;
               m_werr = 0;
            end
            m_err = mis;
            if (!c) begin
               if (m_bits < MAXC) m_bits++;
               if (mis && m_errs < MAXC) m_errs++;
            end
            if (mis) begin
               if (m_werr == LOSS_THRESH) begin
                  m_lost = 1'b1; m_locked = 0; m_n = 0; m_run = 0;
               end
               m_werr++;
            end
         end
      end
      if (c) begin
         m_bits = 0;
         m_errs = 0;
      end
   endtask

   task automatic step(input logic b, input logic v, input logic c);
      bit_in    = b;
      bit_valid = v;
      clr_cnt   = c;
      @(posedge clk);
      #1;
      model_update(b, v, c);
      check("locked", {63'd0, locked}, 64'(m_locked));
      check("bit_err", {63'd0, bit_err}, {63'd0, m_err});
      check("lock_lost", {63'd0, lock_lost}, {63'd0, m_lost});
      check("bit_cnt", 64'(bit_cnt), 64'(m_bits));
      check("err_cnt", 64'(err_cnt), 64'(m_errs));
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      bit_valid = 1'($urandom_range(0, 1));
      bit_in    = 1'($urandom_range(0, 1));
      clr_cnt   = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      check("rst_locked", {63'd0, locked}, 64'd0);
      check("rst_bit_err", {63'd0, bit_err}, 64'd0);
      check("rst_lock_lost", {63'd0, lock_lost}, 64'd0);
      check("rst_bit_cnt", 64'(bit_cnt), 64'd0);
      check("rst_err_cnt", 64'(err_cnt), 64'd0);
      rst = 1'b0;
   endtask

   initial begin
      logic b;
      int   n_lock, nval, nerr, lost_at, any_lock;
      logic mask [20];
      logic [CNT_W-1:0] prev_bits, prev_errs;
      logic             prev_lock;

      seq_str   = "111101011001000";
      pos       = 0;
      rst       = 1'b0;
      bit_in    = 1'b0;
      bit_valid = 1'b0;
      clr_cnt   = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // 1: clean pattern from all-ones, locks after 12 valid bits
      n_lock = 0;
      for (int i = 1; i <= 40 && n_lock == 0; i++) begin
         get_bit(b);
         step(b, 1'b1, 1'b0);
         if (locked === 1'b1) n_lock = i;
      end
      check("s1_lock_bit", 64'(n_lock), 64'd12);
      for (int i = 0; i < 30; i++) begin
         get_bit(b);
         step(b, 1'b1, 1'b0);
      end
      check("s1_bit_cnt", 64'(bit_cnt), 64'd30);
      check("s1_err_cnt", 64'(err_cnt), 64'd0);

      // 2: single inverted bit
      for (int i = 0; i < int'($urandom_range(0, 10)); i++) begin
         get_bit(b);
         step(b, 1'b1, 1'b0);
      end
      get_bit(b);
      step(~b, 1'b1, 1'b0);
      check("s2_bit_err", {63'd0, bit_err}, 64'd1);
      check("s2_err_cnt", 64'(err_cnt), 64'd1);
      for (int i = 0; i < 10; i++) begin
         get_bit(b);
         step(b, 1'b1, 1'b0);
      end
      check("s2_locked", {63'd0, locked}, 64'd1);
      check("s2_err_hold", 64'(err_cnt), 64'd1);

      // 3: five errors in 20 bits inside one window drop lock, then re-lock
      get_bit(b);
      step(b, 1'b1, 1'b1);
      for (int i = 0; i < 2 * WINDOW_LEN && (m_k % WINDOW_LEN) != 0; i++) begin
         get_bit(b);
         step(b, 1'b1, 1'b0);
      end
      foreach (mask[i]) mask[i] = 1'b0;
      nerr = 0;
      while (nerr < 5) begin
         int p;
         p = int'($urandom_range(0, 19));
         if (!mask[p]) begin
            mask[p] = 1'b1;
            nerr++;
         end
      end
      nerr    = 0;
      lost_at = 0;
      for (int i = 0; i < 20 && lost_at == 0; i++) begin
         get_bit(b);
         if (mask[i]) nerr++;
         step(b ^ mask[i], 1'b1, 1'b0);
         if (lock_lost === 1'b1) lost_at = nerr;
      end
      check("s3_lost_at_err", 64'(lost_at), 64'd5);
      check("s3_locked", {63'd0, locked}, 64'd0);
      check("s3_err_cnt", 64'(err_cnt), 64'd5);
      n_lock = 0;
      for (int i = 1; i <= 40 && n_lock == 0; i++) begin
         get_bit(b);
         step(b, 1'b1, 1'b0);
         if (locked === 1'b1) n_lock = i;
      end
      check("s3_relock_bit", 64'(n_lock), 64'd12);

      // 4: constant streams never lock
      do_reset();
      any_lock = 0;
      for (int i = 0; i < 100; i++) begin
         step(1'b0, 1'b1, 1'b0);
         if (locked !== 1'b0) any_lock = 1;
      end
      check("s4_zero_nolock", 64'(any_lock), 64'd0);
      for (int i = 0; i < 100; i++) begin
         step(1'b1, 1'b1, 1'b0);
         if (locked !== 1'b0) any_lock = 1;
      end
      check("s4_one_nolock", 64'(any_lock), 64'd0);

      // 5: valid one cycle in three, random phase, random noise after lock
      do_reset();
      pos    = int'($urandom_range(0, 14));
      n_lock = 0;
      nval   = 0;
      for (int c = 0; c < 400; c++) begin
         prev_bits = bit_cnt;
         prev_errs = err_cnt;
         prev_lock = locked;
         if (c % 3 == 0) begin
            get_bit(b);
            if (n_lock != 0 && $urandom_range(0, 15) == 0) b = ~b;
            step(b, 1'b1, 1'b0);
            nval++;
            if (n_lock == 0 && locked === 1'b1) n_lock = nval;
         end else begin
            step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            if (c == 1 || c == 200) begin
               check("s5_idle_bit_cnt", 64'(bit_cnt), 64'(prev_bits));
               check("s5_idle_err_cnt", 64'(err_cnt), 64'(prev_errs));
               check("s5_idle_locked", {63'd0, locked}, {63'd0, prev_lock});
            end
         end
      end
      check("s5_lock_bit", 64'(n_lock), 64'd12);

      // 6: clear coincident with an errored bit, then reset while locked
      for (int i = 0; i < 40 && m_locked == 0; i++) begin
         get_bit(b);
         step(b, 1'b1, 1'b0);
      end
      check("s6_pre_locked", {63'd0, locked}, 64'd1);
      get_bit(b);
      step(~b, 1'b1, 1'b1);
      check("s6_clr_bit_err", {63'd0, bit_err}, 64'd1);
      check("s6_clr_bit_cnt", 64'(bit_cnt), 64'd0);
      check("s6_clr_err_cnt", 64'(err_cnt), 64'd0);
      get_bit(b);
      step(b, 1'b1, 1'b0);
      check("s6_post_clr_cnt", 64'(bit_cnt), 64'd1);
      do_reset();
      for (int i = 0; i < 5; i++) begin
         get_bit(b);
         step(b, 1'b1, 1'b0);
      end
      check("s6_post_rst_locked", {63'd0, locked}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
